mux_share_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 2:1 datapath mux (and the unit behind it)

---
 rtl/mux_share_arbiter.sv | 98 +++++++++
 tb/tb_mux_share_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// Round-robin owner arbiter for a shared 2:1 mux. The owner holds the path until it
// releases or times out under contention; handover to a waiting peer is back-to-back.
module mux_share_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic last0_i,
    input  logic last1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic sel_o,
    output logic busy_o
);

    localparam int unsigned CntW = $clog2(MAX_HOLD) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            sel_q, sel_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            at_max;

    assign at_max = (hold_cnt_q == CntMax);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req0_i && (!req1_i || !prio_q)) begin
                    state_d = StOwn0;
                end else if (req1_i) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                // Release conditions are OR-ed so last+timeout flips prio only once.
                if (!req0_i || last0_i || (req1_i && at_max)) begin
                    prio_d  = 1'b1;
                    state_d = req1_i ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (!req1_i || last1_i || (req0_i && at_max)) begin
                    prio_d  = 1'b0;
                    state_d = req0_i ? StOwn0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // sel follows the new owner and holds its value through IDLE.
        if (state_d == StOwn0) begin
            sel_d = 1'b0;
        end else if (state_d == StOwn1) begin
            sel_d = 1'b1;
        end

        if (state_d != state_q && state_d != StIdle) begin
            hold_cnt_d = '0;
        end else if (state_q != StIdle && !at_max) begin
            hold_cnt_d = hold_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt0_o = (state_q == StOwn0);
    assign gnt1_o = (state_q == StOwn1);
    assign sel_o  = sel_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed vector table plus hand sequences for the arbiter; random phase checks invariants.
module tb_mux_share_arbiter;

    logic clk;
    logic rst_n;
    logic req0, req1, last0, last1;
    logic gnt0, gnt1, sel, busy;
    logic b_req0, b_req1;
    logic b_gnt0, b_gnt1, b_sel, b_busy;

    int checks = 0;
    int errors = 0;

    mux_share_arbiter #(.MAX_HOLD(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0_i  (req0),
        .req1_i  (req1),
        .last0_i (last0),
        .last1_i (last1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1),
        .sel_o   (sel),
        .busy_o  (busy)
    );

    mux_share_arbiter #(.MAX_HOLD(1)) u_dut_h1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0_i  (b_req0),
        .req1_i  (b_req1),
        .last0_i (1'b0),
        .last1_i (1'b0),
        .gnt0_o  (b_gnt0),
        .gnt1_o  (b_gnt1),
        .sel_o   (b_sel),
        .busy_o  (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r0, r1, l0, l1;
        logic g0, g1, s;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic r0, input logic r1, input logic l0, input logic l1,
                           input logic g0, input logic g1, input logic s);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
        v.g0 = g0; v.g1 = g1; v.s = s;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic g0, input logic g1, input logic s);
        chk({name, " gnt0"}, gnt0, g0);
        chk({name, " gnt1"}, gnt1, g1);
        chk({name, " sel"}, sel, s);
        chk({name, " busy"}, busy, g0 | g1);
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic r0, input logic r1, input logic l0, input logic l1);
        @(negedge clk);
        req0 = r0; req1 = r1; last0 = l0; last1 = l1;
        @(posedge clk);
        #1;
    endtask

    logic pg0, pg1, ps;

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        b_req0 = 0; b_req1 = 0;

        // Single requester, last on 4th beat
        add_vec(1, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0);
        // Short OWN1 to bring prio back to 0; sel holds 1 in IDLE
        add_vec(0, 1, 0, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1);
        // Contention, 4-cycle slices with no bubble
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k == 1) add_vec(1, 1, 0, 0, 0, 1, 1);
                else        add_vec(1, 1, 0, 0, 1, 0, 0);
            end
        end
        // Early last1 at hold_cnt=1 hands back to req0
        add_vec(1, 1, 0, 0, 0, 1, 1);
        add_vec(1, 1, 0, 0, 0, 1, 1);
        add_vec(1, 1, 0, 1, 1, 0, 0);
        // Released requester still requesting waits one cycle in IDLE
        add_vec(1, 0, 1, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0);
        // last0 noise while gnt1 owns
        add_vec(0, 1, 0, 0, 0, 1, 1);
        add_vec(0, 1, 1, 0, 0, 1, 1);
        add_vec(0, 1, 1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].r0, vq[i].r1, vq[i].l0, vq[i].l1);
            chk_out($sformatf("vec%0d", i), vq[i].g0, vq[i].g1, vq[i].s);
        end

        // Uncontended req1 held 10 cycles: never dropped
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 0, 0);
            chk_out($sformatf("solo%0d", i), 1'b0, 1'b1, 1'b1);
        end

        // Hand over to 0 and back to 1 so prio=1 while OWN1
        apply(1, 0, 0, 0);
        chk_out("swap0", 1'b1, 1'b0, 1'b0);
        apply(0, 1, 0, 0);
        chk_out("swap1", 1'b0, 1'b1, 1'b1);

        // Async reset mid-OWN1 drops everything before the next edge
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req0 = 1; req1 = 1; last0 = 0; last1 = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out("postreset_prio", 1'b1, 1'b0, 1'b0);
        apply(0, 0, 0, 0);
        chk_out("postreset_idle", 1'b0, 1'b0, 1'b0);

        // MAX_HOLD=1 alternates every cycle under contention
        @(negedge clk);
        b_req0 = 1; b_req1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("h1_%0d gnt0", i), b_gnt0, (i % 2) == 0);
            chk($sformatf("h1_%0d gnt1", i), b_gnt1, (i % 2) == 1);
            chk($sformatf("h1_%0d sel", i), b_sel, (i % 2) == 1);
            chk($sformatf("h1_%0d busy", i), b_busy, 1'b1);
        end
        @(negedge clk);
        b_req0 = 0; b_req1 = 0;

        // Random traffic: invariants only
        pg0 = gnt0; pg1 = gnt1; ps = sel;
        for (int i = 0; i < 10000; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            chk("rnd mutex", gnt0 & gnt1, 1'b0);
            chk("rnd busy", busy, gnt0 | gnt1);
            chk("rnd sel_stable", (sel != ps) && (gnt0 == pg0) && (gnt1 == pg1), 1'b0);
            if (gnt0 | gnt1) chk("rnd sel_owner", sel, gnt1);
            pg0 = gnt0; pg1 = gnt1; ps = sel;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
